alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Parametrised, registered operand selector for ALU source 1; successor to the 2:1 zero/RS1 select.
- Selects one of NUM_SRC XLEN-bit candidates (slot 0 = zero, slot 1 = RS1, others e.g. PC/imm).
- Forwards from MEM and WB stages when the RS1 slot is chosen.
- Registers the result in a single valid/ready pipeline stage between decode and ALU, with flush and a sticky bad-select flag.

Parameters:
XLEN, 32, operand width in bits
NUM_SRC, 4, number of candidate operand slots (2..16)
SEL_W, 2, width of sel; must satisfy 2**SEL_W >= NUM_SRC
RS_SLOT, 1, slot index subject to register forwarding
REG_AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  drop held operand and any input accepted this cycle
in_valid  in  1  decode offers an operand request
in_ready  out  1  stage can accept this cycle
sel  in  SEL_W  slot select
src_vec  in  NUM_SRC*XLEN  candidate operands; slot k = bits [k*XLEN +: XLEN]; slot 0 driven zero by convention
rs_addr  in  REG_AW  source register address of the RS_SLOT operand
mem_we  in  1  MEM stage writes a register
mem_rd  in  REG_AW  MEM destination register
mem_data  in  XLEN  MEM result
wb_we  in  1  WB stage writes a register
wb_rd  in  REG_AW  WB destination register
wb_data  in  XLEN  WB result
out_valid  out  1  operand held and valid
out_ready  in  1  ALU consumes this cycle
alu_src1  out  XLEN  registered operand
fwd_src  out  2  registered forward origin: 0 none, 1 MEM, 2 WB
sel_err  out  1  sticky: an accepted sel was >= NUM_SRC

Behaviour:
- Reset (async, rst=1): out_valid=0, alu_src1=0, fwd_src=0, sel_err=0, immediately and without a clock.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
  - Accept when in_valid && in_ready.
  - Consume when out_valid && out_ready.
- Latency: exactly 1 cycle; an operand accepted at edge N is presented from edge N until consumed.
- Hold: while out_valid && !out_ready, alu_src1 and fwd_src stay stable and in_ready=0.
- Select (combinational, captured on accept):
  - sel < NUM_SRC: candidate = slot sel.
  - sel >= NUM_SRC: candidate = 0, fwd_src = 0, and sel_err is set on that accept.
- Forwarding applies only when sel == RS_SLOT and rs_addr != 0:
  - If mem_we && mem_rd == rs_addr: use mem_data, fwd_src = 1.
  - Else if wb_we && wb_rd == rs_addr: use wb_data, fwd_src = 2.
  - Else: use slot RS_SLOT, fwd_src = 0.
  - MEM has priority over WB when both match.
  - rs_addr 0 is never forwarded (x0 hard zero).
- Forward values are sampled on the accept edge only; later MEM/WB changes do not alter a held operand.
- Flush:
  - On the edge with flush=1: out_valid <= 0 regardless of in_valid, out_ready or held state.
  - alu_src1 and fwd_src keep their old values (don't-care while invalid).
  - in_ready still reports combinationally, but nothing is captured.
  - sel_err is not set by a request offered during flush.
- Simultaneous consume and accept: new operand loads, out_valid stays 1.
- Consume with no accept: out_valid <= 0.
- sel_err is cleared only by rst.
- Reset mid-operation: held operand is lost; the next request after rst deasserts is accepted normally.

Test Plan:
- Reset: assert rst mid-hold with out_valid=1, alu_src1=0xDEADBEEF -> out_valid, alu_src1, fwd_src, sel_err all 0 before next clk edge.
- Plain select: sel=0 -> alu_src1=0x00000000; sel=1 with slot1=0x12345678 and no matches -> 0x12345678, fwd_src=0; sel=2 with slot2=0x00400000 -> 0x00400000; each 1 cycle after accept, out_ready=1 throughout, in_ready=1 every cycle.
- Forwarding priority:
  - sel=1, rs_addr=5, mem_we=1 mem_rd=5 mem_data=0xAAAA0001, wb_we=1 wb_rd=5 wb_data=0xBBBB0002 -> 0xAAAA0001, fwd_src=1.
  - Same with mem_we=0 -> 0xBBBB0002, fwd_src=2.
  - rs_addr=0 with both matching rd=0 -> slot1 value, fwd_src=0.
- Backpressure: accept 0x11, hold out_ready=0 three cycles while in_valid=1 offers 0x22 -> alu_src1 stays 0x11, in_ready=0. Raise out_ready -> 0x11 consumed and 0x22 accepted on the same edge, out_valid stays 1.
- Flush: out_valid=1 holding 0x33, flush=1 with in_valid=1 offering 0x44 -> next cycle out_valid=0. Following cycle with flush=0 accepts normally.
- Bad select (NUM_SRC=3): sel=3 accepted -> alu_src1=0, sel_err=1. Later valid requests leave sel_err=1 until rst.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Registered ALU source-1 operand selector with MEM/WB forwarding on the RS slot.
// A single valid/ready stage with flush and a sticky out-of-range select flag.
module alu_operand_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned RS_SLOT = 1,
  parameter int unsigned REG_AW  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_SRC*XLEN-1:0] src_vec,
  input  logic [REG_AW-1:0]       rs_addr,
  input  logic                    mem_we,
  input  logic [REG_AW-1:0]       mem_rd,
  input  logic [XLEN-1:0]         mem_data,
  input  logic                    wb_we,
  input  logic [REG_AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         alu_src1,
  output logic [1:0]              fwd_src,
  output logic                    sel_err
);

  localparam logic [1:0] FwdNone = 2'd0;
  localparam logic [1:0] FwdMem  = 2'd1;
  localparam logic [1:0] FwdWb   = 2'd2;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [1:0]      fwd_q, fwd_d;
  logic            err_q, err_d;

  logic            accept;
  logic            consume;
  logic            sel_ok;
  logic            rs_sel;
  logic [XLEN-1:0] cand;
  logic [1:0]      cand_fwd;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = valid_q && out_ready;
  assign sel_ok   = 32'(sel) < NUM_SRC;
  // x0 is hard-wired zero, so it never takes a forwarded value.
  assign rs_sel   = (32'(sel) == RS_SLOT) && (rs_addr != '0);

  always_comb begin
    cand     = '0;
    cand_fwd = FwdNone;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (32'(sel) == k) begin
        cand = src_vec[k*XLEN +: XLEN];
      end
    end
    if (rs_sel) begin
      if (mem_we && (mem_rd == rs_addr)) begin
        cand     = mem_data;
        cand_fwd = FwdMem;
      end else if (wb_we && (wb_rd == rs_addr)) begin
        cand     = wb_data;
        cand_fwd = FwdWb;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    src1_d  = src1_q;
    fwd_d   = fwd_q;
    err_d   = err_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      src1_d  = cand;
      fwd_d   = cand_fwd;
      if (!sel_ok) begin
        err_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      src1_q  <= '0;
      fwd_q   <= FwdNone;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      src1_q  <= src1_d;
      fwd_q   <= fwd_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_src1  = src1_q;
  assign fwd_src   = fwd_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage (NUM_SRC=3): directed vectors,
// handshake corner sequences and a randomized run against a behavioural model.
module tb_alu_operand_stage;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned RS_SLOT = 1;
  localparam int unsigned REG_AW  = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_SRC*XLEN-1:0] src_vec;
  logic [REG_AW-1:0]       rs_addr;
  logic                    mem_we;
  logic [REG_AW-1:0]       mem_rd;
  logic [XLEN-1:0]         mem_data;
  logic                    wb_we;
  logic [REG_AW-1:0]       wb_rd;
  logic [XLEN-1:0]         wb_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         alu_src1;
  logic [1:0]              fwd_src;
  logic                    sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RS_SLOT(RS_SLOT), .REG_AW(REG_AW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .src_vec(src_vec), .rs_addr(rs_addr), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_data(mem_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_src1(alu_src1),
    .fwd_src(fwd_src), .sel_err(sel_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; out_ready = 1; sel = 0; rs_addr = 0;
    mem_we = 0; mem_rd = 0; mem_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    src_vec = '0;
  endtask

  task automatic set_slots(input logic [31:0] s1, input logic [31:0] s2);
    src_vec = {s2, s1, 32'h0};
  endtask

  // Reference: operand picked by the selection and forwarding rules.
  function automatic logic [33:0] ref_op(input int s, input logic [31:0] s1,
      input logic [31:0] s2, input int rs, input bit mwe, input int mrd,
      input logic [31:0] md, input bit wwe, input int wrd, input logic [31:0] wd);
    logic [31:0] slots [3];
    slots[0] = 32'h0; slots[1] = s1; slots[2] = s2;
    if (s >= int'(NUM_SRC)) return {2'd0, 32'h0};
    if (s == int'(RS_SLOT) && rs != 0) begin
      if (mwe && mrd == rs) return {2'd1, md};
      if (wwe && wrd == rs) return {2'd2, wd};
    end
    return {2'd0, slots[s]};
  endfunction

  typedef struct {
    logic [1:0]  s;
    logic [31:0] s1, s2;
    logic [4:0]  rs;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [31:0] exp_val;
    logic [1:0]  exp_fwd;
  } vec_t;

  vec_t vecs [7];

  // Model state for the random phase.
  bit          m_valid;
  logic [31:0] m_val;
  logic [1:0]  m_fwd;
  bit          m_err;

  initial begin
    vecs[0] = '{2'd0, 32'h12345678, 32'h00400000, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                32'h00000000, 2'd0};
    vecs[1] = '{2'd1, 32'h12345678, 32'h00400000, 5'd7, 0, 5'd7, 32'h1, 0, 5'd7, 32'h2,
                32'h12345678, 2'd0};
    vecs[2] = '{2'd2, 32'h12345678, 32'h00400000, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                32'h00400000, 2'd0};
    vecs[3] = '{2'd1, 32'h12345678, 32'h0, 5'd5, 1, 5'd5, 32'hAAAA0001, 1, 5'd5, 32'hBBBB0002,
                32'hAAAA0001, 2'd1};
    vecs[4] = '{2'd1, 32'h12345678, 32'h0, 5'd5, 0, 5'd5, 32'hAAAA0001, 1, 5'd5, 32'hBBBB0002,
                32'hBBBB0002, 2'd2};
    vecs[5] = '{2'd1, 32'h12345678, 32'h0, 5'd0, 1, 5'd0, 32'hAAAA0001, 1, 5'd0, 32'hBBBB0002,
                32'h12345678, 2'd0};
    vecs[6] = '{2'd2, 32'h0, 32'h00400000, 5'd5, 1, 5'd5, 32'hAAAA0001, 0, 5'd0, 32'h0,
                32'h00400000, 2'd0};

    idle();
    rst = 1;
    #12;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset alu_src1", alu_src1, 0);
    chk("reset fwd_src", 32'(fwd_src), 0);
    chk("reset sel_err", 32'(sel_err), 0);
    rst = 0;
    tick();

    // Directed vectors with continuous flow.
    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].s; set_slots(vecs[i].s1, vecs[i].s2); rs_addr = vecs[i].rs;
      mem_we = vecs[i].mwe; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
      wb_we = vecs[i].wwe; wb_rd = vecs[i].wrd; wb_data = vecs[i].wd;
      in_valid = 1; out_ready = 1;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 1);
      tick();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d alu_src1", i), alu_src1, vecs[i].exp_val);
      chk($sformatf("vec%0d fwd_src", i), 32'(fwd_src), 32'(vecs[i].exp_fwd));
    end
    idle();

    // Backpressure: held 0x11 stays put while 0x22 waits.
    sel = 1; set_slots(32'h11, 32'h0); in_valid = 1; out_ready = 1;
    tick();
    chk("bp load", alu_src1, 32'h11);
    out_ready = 0; set_slots(32'h22, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp in_ready low", 32'(in_ready), 0);
      tick();
      chk("bp hold value", alu_src1, 32'h11);
      chk("bp hold valid", 32'(out_valid), 1);
    end
    out_ready = 1;
    #1;
    chk("bp in_ready high", 32'(in_ready), 1);
    tick();
    chk("bp swap value", alu_src1, 32'h22);
    chk("bp swap valid", 32'(out_valid), 1);
    in_valid = 0;
    tick();
    chk("consume drains", 32'(out_valid), 0);

    // Flush drops held 0x33 and ignores 0x44 offered alongside.
    set_slots(32'h33, 32'h0); in_valid = 1;
    tick();
    chk("flush preload", alu_src1, 32'h33);
    out_ready = 0; flush = 1; set_slots(32'h44, 32'h0);
    tick();
    chk("flush valid", 32'(out_valid), 0);
    flush = 0; out_ready = 1;
    tick();
    chk("post flush valid", 32'(out_valid), 1);
    chk("post flush value", alu_src1, 32'h44);
    flush = 1; sel = 3;
    tick();
    chk("flush bad sel valid", 32'(out_valid), 0);
    chk("flush bad sel no err", 32'(sel_err), 0);
    flush = 0;

    // Bad select, then sticky flag through a good request.
    sel = 3; set_slots(32'h55, 32'h66); in_valid = 1;
    tick();
    chk("bad sel value", alu_src1, 0);
    chk("bad sel fwd", 32'(fwd_src), 0);
    chk("bad sel err", 32'(sel_err), 1);
    sel = 2;
    tick();
    chk("good after bad value", alu_src1, 32'h66);
    chk("err sticky", 32'(sel_err), 1);

    // Asynchronous reset while holding 0xDEADBEEF.
    sel = 1; set_slots(32'hDEADBEEF, 32'h0);
    tick();
    out_ready = 0; in_valid = 0;
    tick();
    chk("pre-reset hold", alu_src1, 32'hDEADBEEF);
    #2 rst = 1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 0);
    chk("async rst alu_src1", alu_src1, 0);
    chk("async rst fwd_src", 32'(fwd_src), 0);
    chk("async rst sel_err", 32'(sel_err), 0);
    #1 rst = 0;
    idle();
    sel = 1; set_slots(32'h77, 32'h0); in_valid = 1;
    tick();
    chk("post rst accept", alu_src1, 32'h77);
    chk("post rst valid", 32'(out_valid), 1);

    // Randomized traffic against the model.
    m_valid = 1; m_val = 32'h77; m_fwd = 0; m_err = 0;
    for (int i = 0; i < 400; i++) begin
      logic [33:0] r;
      bit rdy;
      sel = 2'($urandom_range(0, 3));
      set_slots($urandom, $urandom);
      rs_addr = 5'($urandom_range(0, 3));
      mem_we = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_data = $urandom;
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      rdy = !m_valid || out_ready;
      chk("rand in_ready", 32'(in_ready), 32'(rdy));
      r = ref_op(int'(sel), src_vec[32 +: 32], src_vec[64 +: 32], int'(rs_addr), mem_we,
                 int'(mem_rd), mem_data, wb_we, int'(wb_rd), wb_data);
      if (flush) begin
        m_valid = 0;
      end else if (in_valid && rdy) begin
        m_valid = 1; m_val = r[31:0]; m_fwd = r[33:32];
        if (int'(sel) >= int'(NUM_SRC)) m_err = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      tick();
      chk("rand out_valid", 32'(out_valid), 32'(m_valid));
      chk("rand sel_err", 32'(sel_err), 32'(m_err));
      if (m_valid) begin
        chk("rand alu_src1", alu_src1, m_val);
        chk("rand fwd_src", 32'(fwd_src), 32'(m_fwd));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
